// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation sequencer: FSM states,
// bilinear weights (in 1/256 units) and the 16-entry MAC tap table.
package interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Bilinear weights, scaled by 256 (they sum to 256 for each point)
  localparam logic [7:0] WT_NEAR = 8'd88;
  localparam logic [7:0] WT_MID  = 8'd62;
  localparam logic [7:0] WT_FAR  = 8'd44;

  localparam int NUM_PIX   = 25;
  localparam int NUM_TAPS  = 16;
  localparam int NUM_PTS   = 4;
  localparam int ACC_W     = 16;

  // Window pixel indices (r*5+c) of the pixels that are passed straight through
  localparam int PIX_CENTER = 12;  // (2,2)
  localparam int PIX_NE_0   = 14;  // (2,4)
  localparam int PIX_NE_2   = 22;  // (4,2)
  localparam int PIX_NE_4   = 10;  // (2,0)
  localparam int PIX_NE_6   = 2;   // (0,2)

  // One MAC tap: which window pixel to read and the weight to apply
  typedef struct packed {
    logic [4:0] pix;
    logic [7:0] wt;
  } tap_t;

  // Tap table indexed by {point, tap}; points are k=1,3,5,7 in that order
  function automatic tap_t tap_lookup(input logic [3:0] n);
    tap_t t;
    case (n)
      4'd0:    t = '{5'd18, WT_NEAR};  // k=1: p33
      4'd1:    t = '{5'd19, WT_MID};   // k=1: p34
      4'd2:    t = '{5'd23, WT_MID};   // k=1: p43
      4'd3:    t = '{5'd24, WT_FAR};   // k=1: p44
      4'd4:    t = '{5'd16, WT_NEAR};  // k=3: p31
      4'd5:    t = '{5'd15, WT_MID};   // k=3: p30
      4'd6:    t = '{5'd21, WT_MID};   // k=3: p41
      4'd7:    t = '{5'd20, WT_FAR};   // k=3: p40
      4'd8:    t = '{5'd6,  WT_NEAR};  // k=5: p11
      4'd9:    t = '{5'd1,  WT_MID};   // k=5: p01
      4'd10:   t = '{5'd5,  WT_MID};   // k=5: p10
      4'd11:   t = '{5'd0,  WT_FAR};   // k=5: p00
      4'd12:   t = '{5'd8,  WT_NEAR};  // k=7: p13
      4'd13:   t = '{5'd3,  WT_MID};   // k=7: p03
      4'd14:   t = '{5'd9,  WT_MID};   // k=7: p14
      default: t = '{5'd4,  WT_FAR};   // k=7: p04
    endcase
    return t;
  endfunction

endpackage

// File: rtl/interp_mac.sv
// Single multiply-accumulate unit shared by all bilinear points.
// o_sum is the value the accumulator takes on the next enabled edge, so the
// caller can capture a finished point in the same cycle as its last tap.
module interp_mac
  import interp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [7:0]       i_b,
  output logic [ACC_W-1:0] o_sum
);

  logic [ACC_W-1:0]   acc_q;
  logic [WIDTH+7:0]   prod;

  // Product plus either the running sum or zero on the first tap of a point
  always_comb begin
    prod  = i_a * i_b;
    o_sum = (i_clr ? '0 : acc_q) + ACC_W'(prod);
  end

  // Accumulator register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else if (i_en) begin
      acc_q <= o_sum;
    end
  end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Interpolation sequencer: accepts a 5x5 window, computes four bilinear
// points on one time-shared MAC (16 taps), then presents the results and
// pass-through pixels until downstream takes them.
module interp_seq_ctrl
  import interp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FIXED = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_PIX*WIDTH-1:0] i_window,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic [WIDTH-1:0]         o_pixel_center,
  output logic [WIDTH-1:0]         o_q_ne_0,
  output logic [WIDTH-1:0]         o_q_ne_2,
  output logic [WIDTH-1:0]         o_q_ne_4,
  output logic [WIDTH-1:0]         o_q_ne_6,
  output logic [FIXED-1:0]         o_q_ne_1,
  output logic [FIXED-1:0]         o_q_ne_3,
  output logic [FIXED-1:0]         o_q_ne_5,
  output logic [FIXED-1:0]         o_q_ne_7
);

  state_t                   state_q, state_d;
  logic [1:0]               pt_q;    // point counter: 0..3 -> k=1,3,5,7
  logic [1:0]               tap_q;   // tap counter within a point
  logic [NUM_PIX*WIDTH-1:0] win_q;
  logic [ACC_W-1:0]         res_q [NUM_PTS];

  logic                     accept;
  logic                     mac_en;
  logic                     last_tap;
  tap_t                     cur_tap;
  logic [WIDTH-1:0]         cur_pix;
  logic [ACC_W-1:0]         mac_sum;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_busy   = 1'b0;
    accept   = 1'b0;
    mac_en   = 1'b0;
    last_tap = (pt_q == 2'd3) && (tap_q == 2'd3);
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        o_busy = 1'b1;
        mac_en = 1'b1;
        if (last_tap) state_d = ST_OUT;
      end
      ST_OUT: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Point/tap counters: tap is the inner loop, point the outer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pt_q  <= '0;
      tap_q <= '0;
    end else if (accept) begin
      pt_q  <= '0;
      tap_q <= '0;
    end else if (mac_en) begin
      tap_q <= tap_q + 2'd1;
      if (tap_q == 2'd3) pt_q <= pt_q + 2'd1;
    end
  end

  // Window latch: captured once on acceptance, later input changes ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= i_window;
    end
  end

  // Tap operand selection from the latched window
  always_comb begin
    cur_tap = tap_lookup({pt_q, tap_q});
    cur_pix = win_q[int'(cur_tap.pix)*WIDTH +: WIDTH];
  end

  interp_mac #(
    .WIDTH (WIDTH)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (mac_en),
    .i_clr   (tap_q == 2'd0),
    .i_a     (cur_pix),
    .i_b     (cur_tap.wt),
    .o_sum   (mac_sum)
  );

  // Result registers: capture each point on its last tap
  // NOTE: the four result words are reset like ordinary flops; they are
  // few and must read as zero after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PTS; i++) res_q[i] <= '0;
    end else if (mac_en && (tap_q == 2'd3)) begin
      res_q[pt_q] <= mac_sum;
    end
  end

  assign o_pixel_center = win_q[PIX_CENTER*WIDTH +: WIDTH];
  assign o_q_ne_0       = win_q[PIX_NE_0*WIDTH +: WIDTH];
  assign o_q_ne_2       = win_q[PIX_NE_2*WIDTH +: WIDTH];
  assign o_q_ne_4       = win_q[PIX_NE_4*WIDTH +: WIDTH];
  assign o_q_ne_6       = win_q[PIX_NE_6*WIDTH +: WIDTH];

  assign o_q_ne_1 = FIXED'(res_q[0]);
  assign o_q_ne_3 = FIXED'(res_q[1]);
  assign o_q_ne_5 = FIXED'(res_q[2]);
  assign o_q_ne_7 = FIXED'(res_q[3]);

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Self-checking bench for interp_seq_ctrl: a behavioural model computes the
// interpolated points directly from pixel arithmetic and tracks the
// transaction timeline; a compare process checks the DUT every cycle.
module tb_interp_seq_ctrl;

  localparam int W  = 8;
  localparam int FX = 24;
  localparam int WB = 25 * W;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [WB-1:0] i_window;
  logic          i_valid;
  logic          o_ready;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;
  logic [W-1:0]  o_pixel_center, o_q_ne_0, o_q_ne_2, o_q_ne_4, o_q_ne_6;
  logic [FX-1:0] o_q_ne_1, o_q_ne_3, o_q_ne_5, o_q_ne_7;

  interp_seq_ctrl #(.WIDTH(W), .FIXED(FX)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_window       (i_window),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_busy         (o_busy),
    .o_pixel_center (o_pixel_center),
    .o_q_ne_0       (o_q_ne_0),
    .o_q_ne_2       (o_q_ne_2),
    .o_q_ne_4       (o_q_ne_4),
    .o_q_ne_6       (o_q_ne_6),
    .o_q_ne_1       (o_q_ne_1),
    .o_q_ne_3       (o_q_ne_3),
    .o_q_ne_5       (o_q_ne_5),
    .o_q_ne_7       (o_q_ne_7)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge i_clk) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic int pix(input logic [WB-1:0] w, input int r, input int c);
    return int'(w[(r*5+c)*W +: W]);
  endfunction

  // Bilinear point k straight from the weight table (weights in 1/256)
  function automatic int bilin(input logic [WB-1:0] w, input int k);
    case (k)
      1:       return pix(w,3,3)*88 + pix(w,3,4)*62 + pix(w,4,3)*62 + pix(w,4,4)*44;
      3:       return pix(w,3,1)*88 + pix(w,3,0)*62 + pix(w,4,1)*62 + pix(w,4,0)*44;
      5:       return pix(w,1,1)*88 + pix(w,0,1)*62 + pix(w,1,0)*62 + pix(w,0,0)*44;
      default: return pix(w,1,3)*88 + pix(w,0,3)*62 + pix(w,1,4)*62 + pix(w,0,4)*44;
    endcase
  endfunction

  function automatic logic [WB-1:0] rand_window();
    logic [WB-1:0] w;
    for (int p = 0; p < 25; p++) w[p*W +: W] = W'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [WB-1:0] set_pix(input logic [WB-1:0] w, input int r,
                                            input int c, input int v);
    logic [WB-1:0] t;
    t = w;
    t[(r*5+c)*W +: W] = W'(v);
    return t;
  endfunction

  // Transaction timeline: a window is taken when idle and i_valid is high;
  // results appear 16 edges later and stay until i_ready is seen.
  logic          m_busy;
  int            m_cnt;
  logic [WB-1:0] m_win;
  int            m_exp [4];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_win  <= '0;
      for (int k = 0; k < 4; k++) m_exp[k] <= 0;
    end else if (!m_busy) begin
      if (i_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_win  <= i_window;
        for (int k = 0; k < 4; k++) m_exp[k] <= bilin(i_window, 2*k + 1);
      end
    end else if (m_cnt < 16) begin
      m_cnt <= m_cnt + 1;
    end else if (i_ready) begin
      m_busy <= 1'b0;
    end
  end

  wire m_valid = m_busy && (m_cnt == 16);

  // Per-cycle comparison against the model
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      check("ready", o_ready, !m_busy);
      check("busy",  o_busy,  m_busy);
      check("valid", o_valid, m_valid);
      if (m_valid) begin
        check("q1", o_q_ne_1, m_exp[0]);
        check("q3", o_q_ne_3, m_exp[1]);
        check("q5", o_q_ne_5, m_exp[2]);
        check("q7", o_q_ne_7, m_exp[3]);
        check("center", o_pixel_center, pix(m_win,2,2));
        check("q0", o_q_ne_0, pix(m_win,2,4));
        check("q2", o_q_ne_2, pix(m_win,4,2));
        check("q4", o_q_ne_4, pix(m_win,2,0));
        check("q6", o_q_ne_6, pix(m_win,0,2));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer a window, wait for acceptance, then wait for results. With noise
  // set, the window and i_valid are scrambled during CALC and i_ready pulses
  // early in CALC. Returns at a negedge with o_valid seen and i_ready low.
  task automatic start_and_wait(input logic [WB-1:0] win, input bit noise);
    int acc_edge;
    bit ok;
    i_window = win;
    i_valid  = 1'b1;
    i_ready  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_ready) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
    check("accept_seen", ok, 1);
    acc_edge = edge_cnt + 1;
    @(negedge i_clk);
    if (!noise) i_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) begin ok = 1'b1; break; end
      if (noise) begin
        i_window = rand_window();
        i_ready  = (i < 10);
      end
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    // first rising edge that samples o_valid high is the accept edge + 17
    check("latency", ok ? (edge_cnt + 1 - acc_edge) : 0, 17);
  endtask

  // Hold results for 'stall' cycles, then hand them off. i_valid is held
  // high through the exit edge, which must not be taken as a new window.
  task automatic finish_window(input int stall);
    repeat (stall) @(negedge i_clk);
    i_ready  = 1'b1;
    i_valid  = 1'b1;
    i_window = rand_window();
    @(negedge i_clk);
    i_ready = 1'b0;
    i_valid = 1'b0;
    check("exit_valid_low", o_valid, 0);
    check("exit_idle", o_busy, 0);
    @(negedge i_clk);
  endtask

  // ---------------- stimulus ----------------
  logic [WB-1:0] flat, w33, wcorner;
  int            acc_q[$];
  int            seen_valid;

  initial begin
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_window = '0;
    flat = '0;
    for (int p = 0; p < 25; p++) flat[p*W +: W] = W'(100);
    w33     = set_pix('0, 3, 3, 255);
    wcorner = set_pix(set_pix(set_pix(set_pix('0, 4, 4, 255), 4, 0, 255), 0, 0, 255), 0, 4, 255);

    // Pin the reference model to hand-computed values
    check("model_flat_k1",   bilin(flat, 1),    'h6400);
    check("model_p33_k1",    bilin(w33, 1),     'h57A8);
    check("model_p33_k3",    bilin(w33, 3),     0);
    check("model_corner_k5", bilin(wcorner, 5), 'h2BD4);

    repeat (3) @(negedge i_clk);
    check("rst_valid",  o_valid,  0);
    check("rst_busy",   o_busy,   0);
    check("rst_q1",     o_q_ne_1, 0);
    check("rst_q7",     o_q_ne_7, 0);
    check("rst_center", o_pixel_center, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_ready", o_ready, 1);

    // Flat window
    start_and_wait(flat, 1'b0);
    check("flat_q1", o_q_ne_1, 'h006400);
    check("flat_q3", o_q_ne_3, 'h006400);
    check("flat_q5", o_q_ne_5, 'h006400);
    check("flat_q7", o_q_ne_7, 'h006400);
    check("flat_center", o_pixel_center, 100);
    check("flat_q0", o_q_ne_0, 100);
    check("flat_q6", o_q_ne_6, 100);
    finish_window(0);

    // Single bright pixel, input noise during CALC, 10-cycle stall in OUT
    start_and_wait(w33, 1'b1);
    check("p33_q1", o_q_ne_1, 'h0057A8);
    check("p33_q3", o_q_ne_3, 0);
    check("p33_q5", o_q_ne_5, 0);
    check("p33_q7", o_q_ne_7, 0);
    finish_window(10);
    check("p33_ready_after", o_ready, 1);

    // Four far corners
    start_and_wait(wcorner, 1'b0);
    check("corner_q1", o_q_ne_1, 'h002BD4);
    check("corner_q3", o_q_ne_3, 'h002BD4);
    check("corner_q5", o_q_ne_5, 'h002BD4);
    check("corner_q7", o_q_ne_7, 'h002BD4);
    finish_window(3);

    // Reset pulse in the middle of CALC
    i_window = rand_window();
    i_valid  = 1'b1;
    @(negedge i_clk);
    check("mid_accept_ready", o_ready, 0);
    i_valid = 1'b0;
    repeat (8) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_busy",  o_busy,  0);
    check("midrst_q1",    o_q_ne_1, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge i_clk);
      if (o_valid) seen_valid++;
    end
    check("midrst_no_valid", seen_valid, 0);
    i_ready = 1'b0;
    start_and_wait(rand_window(), 1'b0);
    finish_window(1);

    // Back-to-back windows with i_ready held high
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 5*18 + 4; i++) begin
      i_window = rand_window();
      if (o_ready) acc_q.push_back(edge_cnt + 1);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    repeat (20) @(negedge i_clk);
    i_ready = 1'b0;
    check("b2b_count", acc_q.size(), 6);
    for (int i = 1; i < acc_q.size(); i++)
      check("b2b_period", acc_q[i] - acc_q[i-1], 18);

    // Random windows with random stalls
    for (int n = 0; n < 6; n++) begin
      start_and_wait(rand_window(), n[0]);
      finish_window($urandom_range(0, 5));
    end

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interp_seq_ctrl.md
INTERP_SEQ_CTRL -- requirements
Module: interp_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter FIXED, default 24, meaning width of each interpolated result (8 fractional bits).
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_window  input  25*WIDTH  5x5 window; pixel (r,c) at bits [(r*5+c)*WIDTH +: WIDTH].
REQ-006 SHALL have port i_valid  input  1  window valid.
REQ-007 SHALL have port o_ready  output  1  block can accept a window.
REQ-008 SHALL have port o_valid  output  1  results valid.
REQ-009 SHALL have port i_ready  input  1  downstream accepts results.
REQ-010 SHALL have port o_busy  output  1  window accepted, results not yet delivered.
REQ-011 SHALL have port o_pixel_center  output  WIDTH  pixel (2,2).
REQ-012 SHALL have ports o_q_ne_0/2/4/6  output  WIDTH each  pixels (2,4),(4,2),(2,0),(0,2).
REQ-013 SHALL have ports o_q_ne_1/3/5/7  output  FIXED each  bilinear points k=1,3,5,7.

Function
REQ-014 SHALL time-share one 8x8 multiply-accumulate unit across the four bilinear points: 4 taps per point, 16 MAC cycles per window.
REQ-015 SHALL use the tap/weight table (weights /256): k=1: p33*88, p34*62, p43*62, p44*44; k=3: p31*88, p30*62, p41*62, p40*44; k=5: p11*88, p01*62, p10*62, p00*44; k=7: p13*88, p03*62, p14*62, p04*44.
REQ-016 SHALL accumulate each point in 16 bits without rounding or saturation (max 255*256=65280); o_q_ne_k SHALL be the accumulator zero-extended to FIXED.
REQ-017 SHALL implement FSM IDLE -> CALC -> OUT -> IDLE.
REQ-018 IDLE: o_ready=1; on i_valid&&o_ready, latch i_window, clear point/tap counters, go to CALC.
REQ-019 CALC: one tap per cycle, tap counter 0..3 inner, point counter 0..3 (k=1,3,5,7) outer; after tap 3 of k=7, go to OUT.
REQ-020 OUT: o_valid=1, outputs stable; on i_ready go to IDLE in the next cycle.
REQ-021 Latency: o_valid SHALL rise exactly 17 cycles after the accepting edge; throughput one window per 18 cycles with i_ready held high.
REQ-022 o_ready SHALL be 0 in CALC and OUT; i_valid there SHALL be ignored and no window accepted on the cycle OUT exits.
REQ-023 i_window changes after acceptance SHALL NOT affect results.
REQ-024 i_ready outside OUT SHALL have no effect; o_valid SHALL stay high until i_ready is sampled.
REQ-025 o_busy SHALL be 1 in CALC and OUT, 0 in IDLE.
REQ-026 Pass-through outputs SHALL come from the latched window and be valid whenever o_valid=1.

Reset
REQ-027 On i_rst_n low, SHALL immediately enter IDLE: o_valid=0, o_busy=0, o_ready=1 after release, all result/latched registers and counters 0.
REQ-028 Reset mid-CALC or mid-OUT SHALL discard the window; no o_valid until a new window is accepted.

Structure
REQ-029 Package interp_pkg SHALL hold the FSM state enum, weight constants (88, 62, 44), and the 16-entry tap table (pixel index, weight).
REQ-030 SHALL contain one sub-module interp_mac (8x8 multiply, 16-bit accumulate, clear input).

Verification
REQ-031 Flat window all 100 -> o_q_ne_1/3/5/7 = 0x006400, even outputs and center = 100, o_valid at cycle 17.
REQ-032 Window with p33=255, others 0 -> o_q_ne_1=0x0057A8 (255*88), o_q_ne_3/5/7=0.
REQ-033 p44=p40=p00=p04=255, others 0 -> every odd output = 0x002BD4 (255*44).
REQ-034 i_ready low 10 cycles in OUT -> outputs and o_valid held; i_valid during CALC ignored, o_ready=0.
REQ-035 i_rst_n pulsed low at CALC cycle 8 -> o_valid/o_busy 0 at once; next window gives correct results at latency 17.
REQ-036 Back-to-back windows, i_ready=1 -> accepts every 18 cycles, each result matches the reference model.
